// File: rtl/cg_ctrl_pkg.sv
// rtl/cg_ctrl_pkg.sv - phase encodings, default sizes and phase helpers for the CG sequencer
package cg_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MXV    = 3'd1,
    VXV1   = 3'd2,
    UPD_XR = 3'd3,
    VXV2   = 3'd4,
    UPD_P  = 3'd5,
    CHECK  = 3'd6,
    DONE   = 3'd7
  } cg_phase_e;

  localparam int DEF_NO_OF_UNITS        = 8;
  localparam int DEF_EQUATIONS          = 24;
  localparam int DEF_ADDR_WIDTH         = 20;
  localparam int DEF_NUMBER_OF_CLUSTERS = 40;
  localparam int DEF_MAX_ITERATIONS     = 20;
  localparam int DEF_ITER_WIDTH         = 11;

  function automatic logic is_read_phase(input cg_phase_e p);
    return p inside {MXV, VXV1, UPD_XR, VXV2, UPD_P};
  endfunction

  // Successor of a sweeping phase; UPD_P hands over to the one-cycle CHECK.
  function automatic cg_phase_e next_phase(input cg_phase_e p);
    case (p)
      MXV:     return VXV1;
      VXV1:    return UPD_XR;
      UPD_XR:  return VXV2;
      VXV2:    return UPD_P;
      UPD_P:   return CHECK;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/wrap_addr_counter.sv
// rtl/wrap_addr_counter.sv - address counter that wraps limit -> 0, with synchronous clear
module wrap_addr_counter #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = en && (count == limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cg_phase_sequencer.sv
// rtl/cg_phase_sequencer.sv - CG iteration phase FSM driving read/write addresses
// Optional busy-cycle counter is built only when CG_CYCLE_COUNTER_EN is defined.
module cg_phase_sequencer
  import cg_ctrl_pkg::*;
#(
  parameter int NO_OF_UNITS        = DEF_NO_OF_UNITS,
  parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
  parameter int NUMBER_OF_CLUSTERS = DEF_NUMBER_OF_CLUSTERS,
  parameter int VECTOR_WORDS       = (DEF_EQUATIONS + NO_OF_UNITS - 1) / NO_OF_UNITS,
  parameter int MAX_ITERATIONS     = DEF_MAX_ITERATIONS,
  parameter int ITER_WIDTH         = DEF_ITER_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  rd_stall,
  input  logic                  phase_done,
  input  logic                  converged,
  input  logic                  x_we_in,
  input  logic                  r_we_in,
  input  logic                  p_we_in,
  output logic [ADDR_WIDTH-1:0] memoryA_read_address,
  output logic [ADDR_WIDTH-1:0] memoryP_read_address,
  output logic [ADDR_WIDTH-1:0] memoryP_v2_read_address,
  output logic [ADDR_WIDTH-1:0] memoryR_read_address,
  output logic [ADDR_WIDTH-1:0] memoryX_read_address,
  output logic                  rd_en,
  output logic                  memoryX_write_enable,
  output logic                  memoryR_write_enable,
  output logic                  memoryP_write_enable,
  output logic [ADDR_WIDTH-1:0] memoryX_write_address,
  output logic [ADDR_WIDTH-1:0] memoryR_write_address,
  output logic [ADDR_WIDTH-1:0] memoryP_write_address,
  output logic [2:0]            phase,
  output logic [ITER_WIDTH-1:0] iteration_counter,
  output logic                  busy,
  output logic                  halt,
  output logic [31:0]           cycle_count
);

  localparam logic [ADDR_WIDTH-1:0] MXV_LAST = ADDR_WIDTH'(NUMBER_OF_CLUSTERS - 1);
  localparam logic [ADDR_WIDTH-1:0] VEC_LAST = ADDR_WIDTH'(VECTOR_WORDS - 1);

  cg_phase_e             state;
  logic                  issuing, sweep_done, pd_latch;
  logic                  a_en, p_en, p2_en, r_en, x_en;
  logic                  a_wrap, p_wrap, p2_wrap, r_wrap, x_wrap, lead_wrap;
  logic                  start_go, advance, entry, cnt_clr;
  logic                  x_wr, r_wr, p_wr;
  logic [ADDR_WIDTH-1:0] x_wcount, r_wcount, p_wcount;
  logic [2:0]            unused_wr_wrap;
  logic [ITER_WIDTH-1:0] iter_next;

  assign phase = state;
  assign busy  = (state != IDLE) && (state != DONE);
  assign halt  = (state == DONE);
  assign rd_en = issuing && !rd_stall;

  assign a_en  = rd_en && (state == MXV);
  assign p_en  = rd_en && (state == MXV);
  assign p2_en = rd_en && (state inside {VXV1, UPD_XR, UPD_P});
  assign r_en  = rd_en && (state inside {VXV1, UPD_XR, VXV2, UPD_P});
  assign x_en  = rd_en && (state == UPD_XR);

  // All counters active in a phase share one limit, so any of them marks the last issue.
  assign lead_wrap = a_wrap | p_wrap | p2_wrap | r_wrap | x_wrap;
  assign start_go  = start && !abort && ((state == IDLE) || (state == DONE));
  assign advance   = is_read_phase(state) && (sweep_done || lead_wrap) && (pd_latch || phase_done);
  assign entry     = !abort && (start_go || advance || (state == CHECK));
  assign cnt_clr   = abort || entry;
  assign iter_next = iteration_counter + ITER_WIDTH'(1);

  assign x_wr = x_we_in && !abort && (state == UPD_XR);
  assign r_wr = r_we_in && !abort && (state == UPD_XR);
  assign p_wr = p_we_in && !abort && (state == UPD_P);

  wrap_addr_counter #(.WIDTH(ADDR_WIDTH)) u_rd_a (
    .clk(clk), .reset(reset), .en(a_en), .clr(cnt_clr), .limit(MXV_LAST),
    .count(memoryA_read_address), .wrap(a_wrap));
  wrap_addr_counter #(.WIDTH(ADDR_WIDTH)) u_rd_p (
    .clk(clk), .reset(reset), .en(p_en), .clr(cnt_clr), .limit(MXV_LAST),
    .count(memoryP_read_address), .wrap(p_wrap));
  wrap_addr_counter #(.WIDTH(ADDR_WIDTH)) u_rd_p2 (
    .clk(clk), .reset(reset), .en(p2_en), .clr(cnt_clr), .limit(VEC_LAST),
    .count(memoryP_v2_read_address), .wrap(p2_wrap));
  wrap_addr_counter #(.WIDTH(ADDR_WIDTH)) u_rd_r (
    .clk(clk), .reset(reset), .en(r_en), .clr(cnt_clr), .limit(VEC_LAST),
    .count(memoryR_read_address), .wrap(r_wrap));
  wrap_addr_counter #(.WIDTH(ADDR_WIDTH)) u_rd_x (
    .clk(clk), .reset(reset), .en(x_en), .clr(cnt_clr), .limit(VEC_LAST),
    .count(memoryX_read_address), .wrap(x_wrap));

  wrap_addr_counter #(.WIDTH(ADDR_WIDTH)) u_wr_x (
    .clk(clk), .reset(reset), .en(x_wr), .clr(cnt_clr), .limit(VEC_LAST),
    .count(x_wcount), .wrap(unused_wr_wrap[0]));
  wrap_addr_counter #(.WIDTH(ADDR_WIDTH)) u_wr_r (
    .clk(clk), .reset(reset), .en(r_wr), .clr(cnt_clr), .limit(VEC_LAST),
    .count(r_wcount), .wrap(unused_wr_wrap[1]));
  wrap_addr_counter #(.WIDTH(ADDR_WIDTH)) u_wr_p (
    .clk(clk), .reset(reset), .en(p_wr), .clr(cnt_clr), .limit(VEC_LAST),
    .count(p_wcount), .wrap(unused_wr_wrap[2]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      issuing           <= 1'b0;
      sweep_done        <= 1'b0;
      pd_latch          <= 1'b0;
      iteration_counter <= '0;
    end else if (abort) begin
      state      <= IDLE;
      issuing    <= 1'b0;
      sweep_done <= 1'b0;
      pd_latch   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state             <= MXV;
            issuing           <= 1'b1;
            iteration_counter <= '0;
          end
        end
        CHECK: begin
          iteration_counter <= iter_next;
          sweep_done        <= 1'b0;
          pd_latch          <= 1'b0;
          if (converged || (iter_next == ITER_WIDTH'(MAX_ITERATIONS))) begin
            state <= DONE;
          end else begin
            state   <= MXV;
            issuing <= 1'b1;
          end
        end
        default: begin
          if (advance) begin
            state      <= next_phase(state);
            issuing    <= is_read_phase(next_phase(state));
            sweep_done <= 1'b0;
            pd_latch   <= 1'b0;
          end else begin
            if (lead_wrap) begin
              issuing    <= 1'b0;
              sweep_done <= 1'b1;
            end
            if (phase_done) pd_latch <= 1'b1;
          end
        end
      endcase
    end
  end

  // Write address registers capture the counter value before its increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || abort) begin
      memoryX_write_enable  <= 1'b0;
      memoryR_write_enable  <= 1'b0;
      memoryP_write_enable  <= 1'b0;
      memoryX_write_address <= '0;
      memoryR_write_address <= '0;
      memoryP_write_address <= '0;
    end else begin
      memoryX_write_enable <= x_wr;
      memoryR_write_enable <= r_wr;
      memoryP_write_enable <= p_wr;
      if (x_wr) memoryX_write_address <= x_wcount;
      if (r_wr) memoryR_write_address <= r_wcount;
      if (p_wr) memoryP_write_address <= p_wcount;
    end
  end

`ifdef CG_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_q <= '0;
    end else if (start_go) begin
      cycle_cnt_q <= '0;
    end else if (busy && (cycle_cnt_q != '1)) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
  end

  assign cycle_count = cycle_cnt_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: doc/cg_phase_sequencer.md
# cg_phase_sequencer

Parametrised address and phase sequencer for the conjugate-gradient solver datapath. Replaces the free-running per-memory address counters with one explicit phase FSM that drives the A/P/P2/R/X read addresses and P/R/X write addresses for each CG iteration. It also counts iterations and stops on convergence or on the iteration limit. Sits between the top-level start/halt logic and the mXv/vXv/ALU units.

## Interface
- NO_OF_UNITS, 8: parallel lanes per vector word (informational; sets VECTOR_WORDS default)
- ADDR_WIDTH, 20: width of every memory address
- NUMBER_OF_CLUSTERS, 40: A/P row-cluster reads per mXv phase
- VECTOR_WORDS, 3: words per vector memory (ceil(equations/NO_OF_UNITS))
- MAX_ITERATIONS, 20: iteration limit, >=1
- ITER_WIDTH, 11: iteration counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin solve; sampled in IDLE and DONE
- abort  in  1  return to IDLE next cycle
- rd_stall  in  1  hold all read addresses this cycle
- phase_done  in  1  datapath finished current phase's arithmetic (pulse)
- converged  in  1  residual below threshold; valid in CHECK
- x_we_in, r_we_in, p_we_in  in  1 each  datapath result-write strobes
- memoryA_read_address, memoryP_read_address  out  ADDR_WIDTH  mXv operand addresses
- memoryP_v2_read_address, memoryR_read_address, memoryX_read_address  out  ADDR_WIDTH  vector operand addresses
- rd_en  out  1  read addresses valid this cycle
- memoryX/R/P_write_enable  out  1 each  registered write enables
- memoryX/R/P_write_address  out  ADDR_WIDTH each  write addresses
- phase  out  3  current FSM state encoding
- iteration_counter  out  ITER_WIDTH  completed iterations
- busy, halt  out  1 each  solving / finished
- cycle_count  out  32  busy cycles (see Configuration)

## Operation
- States: IDLE, MXV, VXV1, UPD_XR, VXV2, UPD_P, CHECK, DONE.
- IDLE -start-> MXV. Phases advance MXV->VXV1->UPD_XR->VXV2->UPD_P->CHECK.
- Read issue per phase: MXV sweeps A and P 0..NUMBER_OF_CLUSTERS-1. VXV1 sweeps P2 and R. UPD_XR sweeps X, P2 and R. VXV2 sweeps R. UPD_P sweeps R and P2. Vector sweeps run 0..VECTOR_WORDS-1. Unused addresses hold 0.
- One address per cycle with rd_en=1. rd_stall freezes addresses and drops rd_en.
- Phase exit requires sweep complete AND phase_done. phase_done arriving early is latched; the latch clears on phase entry.
- Write strobes: a write counter per memory increments on each strobe and wraps VECTOR_WORDS-1 -> 0. All write counters clear on phase entry. Strobes outside UPD_XR (X, R) or UPD_P (P) are ignored.
- CHECK (one cycle): iteration_counter increments. If converged or the new count == MAX_ITERATIONS, go to DONE; otherwise go to MXV.
- DONE: halt=1, busy=0. start -> clears iteration_counter, goes to MXV.
- abort in any state -> IDLE. Counters, addresses and latches clear; iteration_counter holds.
- Reset values: state IDLE, all addresses 0, all enables 0, rd_en 0, iteration_counter 0, halt 0, busy 0, cycle_count 0.

## Timing
- start high in IDLE at edge n: phase=MXV, rd_en=1, addresses=0 after edge n+1.
- Last sweep address is visible for one cycle, then addresses return to 0 and rd_en=0.
- Write strobe at edge n: write_enable=1 with the counter's pre-increment address after edge n+1 (one-cycle latency).
- abort has priority over phase_done, start and write strobes in the same cycle.
- Reset asserted mid-phase clears everything asynchronously. Nothing is resumed after reset.

## Configuration
- CG_CYCLE_COUNTER_EN defined: cycle_count increments every cycle busy=1, saturates at 2^32-1, clears on start.
- Not defined: cycle_count is tied to 0 and no counter logic is built.

## Structure
- cg_ctrl_pkg holds the phase enum, phase encodings and the default size constants.
- Sub-module wrap_addr_counter (enable, clear, limit, wrap flag) is instantiated once per read and write address.

## Test plan
- Full iteration, CLUSTERS=40, WORDS=3, phase_done 2 cycles after each sweep -> phases in order, A/P reach 39, vectors reach 2, iteration_counter=1.
- converged never asserted, MAX_ITERATIONS=20 -> DONE after the 20th CHECK, halt=1, iteration_counter=20.
- phase_done early in VXV1 (cycle 0) -> VXV1 still sweeps 0..2 before exiting.
- Four x_we_in strobes in UPD_XR -> write addresses 0,1,2,0, each one cycle late. A p_we_in strobe in UPD_XR -> no P write.
- rd_stall asserted for 3 cycles at MXV address 10 -> address holds 10, rd_en=0, sweep still ends at 39.
- abort during UPD_P, then reset pulse mid-MXV -> IDLE with all outputs at reset values. With CG_CYCLE_COUNTER_EN, cycle_count stops incrementing.
